reg_file_32x32: RTL and testbench

- General-purpose register file of the single-cycle MIPS CPU.
- Consumes the 5-bit write-register address produced by the write-destination select mux (rt / rd / $31) and the write-back data from the WB select path.
- Provides two combinational read ports to the decode/ALU operand path.
- Provides a third debug read port for the board display and testbenches.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/reg_file_rd_port.sv | 40 ++++
 rtl/reg_file_32x32.sv | 91 +++++++++
 tb/tb_reg_file_32x32.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, register aliases and the
// write-destination select encoding used ahead of the register file.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [31:0]           word_t;

  // Architectural register aliases
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_GP   = 5'd28;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

  // Write-destination mux select: rt (I-type), rd (R-type), $31 (jal link)
  localparam logic [1:0] WDST_RT = 2'd0;
  localparam logic [1:0] WDST_RD = 2'd1;
  localparam logic [1:0] WDST_RA = 2'd2;

  // Write-destination mux; the unused encoding targets $0 so nothing is written
  function automatic reg_addr_t wdst_mux(input logic [1:0] sel,
                                         input reg_addr_t  rt,
                                         input reg_addr_t  rd);
    case (sel)
      WDST_RT: return rt;
      WDST_RD: return rd;
      WDST_RA: return REG_RA;
      default: return REG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file: $0 reads as zero and,
// when REG_FILE_BYPASS_EN is defined, a same-cycle write to the addressed
// register is forwarded to the output ahead of the clock edge.
module reg_file_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  reg_addr_t                        ra,
  input  logic [REG_NUM-1:0][DATA_W-1:0]   regs,
  input  logic                             we,
  input  reg_addr_t                        wa,
  input  logic [DATA_W-1:0]                wd,
  output logic [DATA_W-1:0]                rd
);

`ifndef REG_FILE_BYPASS_EN
  // Write-port inputs only matter for forwarding; fold them into a sink
  logic unused_wr;
  assign unused_wr = ^{we, wa, wd};
`endif

  // Select stored contents (or forwarded write data), with $0 forced to zero
  always_comb begin
    // NOTE: default assignment first so every path drives rd; otherwise a latch is inferred.
    rd = '0;
    if (ra != REG_ZERO) begin
`ifdef REG_FILE_BYPASS_EN
      if (we && (wa != REG_ZERO) && (wa == ra)) begin
        rd = wd;
      end else begin
        rd = regs[ra];
      end
`else
      rd = regs[ra];
`endif
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// MIPS general-purpose register file: 31 storage registers ($1..$31),
// one synchronous write port, two operand read ports and one debug read port.
// $28/$29 reset to GP_INIT/SP_INIT; everything else resets to zero.
// Optional build macro: REG_FILE_BYPASS_EN (write-through forwarding on reads).
module reg_file_32x32
  import cpu_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  reg_addr_t         RA1,
  input  reg_addr_t         RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE,
  input  reg_addr_t         WA,
  input  logic [DATA_W-1:0] WD,
  input  reg_addr_t         DBG_A,
  output logic [DATA_W-1:0] DBG_D
);

  // Storage exists only for $1..$31
  logic [DATA_W-1:0] regs_q [1:REG_NUM-1];

  // Full 32-entry view handed to the read ports; entry 0 is a constant zero
  logic [REG_NUM-1:0][DATA_W-1:0] regs_view;

  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    if (idx == int'(REG_GP)) return GP_INIT;
    if (idx == int'(REG_SP)) return SP_INIT;
    return '0;
  endfunction

  // Register array: asynchronous reset to architectural init values, write on rising edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: this array is flops, not a RAM macro, so resetting every entry is legal and required here.
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= reset_value(i);
      end
    end else if (WE && (WA != REG_ZERO)) begin
      // NOTE: non-blocking assignment so reads in the same edge see the old value.
      regs_q[WA] <= WD;
    end
  end

  // Build the read view with $0 hard-wired to zero
  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  reg_file_rd_port #(.DATA_W(DATA_W)) u_rd1 (
    .ra   (RA1),
    .regs (regs_view),
    .we   (WE),
    .wa   (WA),
    .wd   (WD),
    .rd   (RD1)
  );

  reg_file_rd_port #(.DATA_W(DATA_W)) u_rd2 (
    .ra   (RA2),
    .regs (regs_view),
    .we   (WE),
    .wa   (WA),
    .wd   (WD),
    .rd   (RD2)
  );

  reg_file_rd_port #(.DATA_W(DATA_W)) u_dbg (
    .ra   (DBG_A),
    .regs (regs_view),
    .we   (WE),
    .wa   (WA),
    .wd   (WD),
    .rd   (DBG_D)
  );

`ifndef SYNTHESIS
  // A write with an unknown destination would corrupt an unpredictable register
  wa_known_a: assert property (@(posedge CLK) disable iff (!RST_N) WE |-> !$isunknown(WA))
    else $error("reg_file_32x32: WE=1 with unknown WA");
`endif

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: directed scenarios followed by
// randomized traffic compared against an array model of the register file.
`timescale 1ns/1ps
module tb_reg_file_32x32;
  import cpu_pkg::*;

  logic      CLK = 1'b0;
  logic      RST_N;
  reg_addr_t RA1, RA2, WA, DBG_A;
  word_t     RD1, RD2, WD, DBG_D;
  logic      WE;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: architectural contents of $0..$31
  word_t model [0:31];

  reg_file_32x32 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RA1   (RA1),
    .RA2   (RA2),
    .RD1   (RD1),
    .RD2   (RD2),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .DBG_A (DBG_A),
    .DBG_D (DBG_D)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value given the model and the write port currently presented
  function automatic word_t exp_rd(input reg_addr_t a);
    if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (RST_N && WE && WA != 5'd0 && WA == a) return WD;
`endif
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[28] = 32'h0000_1800;
    model[29] = 32'h0000_3FFC;
  endtask

  // One rising edge; the model commits whatever the DUT should commit
  task automatic tick();
    @(posedge CLK);
    if (RST_N && WE && WA != 5'd0) model[WA] = WD;
    #1;
  endtask

  // Walk every address through the debug port (WE must be 0)
  task automatic sweep(input string tag);
    for (int a = 0; a < 32; a++) begin
      DBG_A = reg_addr_t'(a);
      #0.1;
      check($sformatf("%s[%0d]", tag, a), DBG_D, exp_rd(DBG_A));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b1; WE = 1'b0; WA = '0; WD = '0;
    RA1 = '0; RA2 = '0; DBG_A = '0;
    model_reset();

    // Reset asserted mid-cycle, outputs checked before any clock edge
    #2;
    RST_N = 1'b0;
    RA1 = 5'd29; RA2 = 5'd28; DBG_A = 5'd5;
    #1;
    check("rst_rd1_sp", RD1, 32'h0000_3FFC);
    check("rst_rd2_gp", RD2, 32'h0000_1800);
    check("rst_dbg_5", DBG_D, 32'h0);
    sweep("rst_sweep");

    // A write presented while reset is held is lost
    @(negedge CLK);
    WE = 1'b1; WA = 5'd5; WD = 32'hCAFE_F00D;
    tick();
    @(negedge CLK);
    WE = 1'b0; RST_N = 1'b1; DBG_A = 5'd5;
    #1;
    check("rst_write_lost", DBG_D, 32'h0);

    // Basic write then read; WE=0 leaves the register alone
    @(negedge CLK);
    WE = 1'b1; WA = 5'd8; WD = 32'hDEAD_BEEF; RA1 = 5'd8;
    tick();
    @(negedge CLK);
    WE = 1'b0; WD = 32'h1234_5678;
    #1;
    check("basic_rd1", RD1, 32'hDEAD_BEEF);
    tick();
    check("we0_hold", RD1, 32'hDEAD_BEEF);

    // $0 immunity
    @(negedge CLK);
    WE = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; RA1 = 5'd0;
    #1;
    check("zero_pre_edge", RD1, 32'h0);
    tick();
    @(negedge CLK);
    WE = 1'b0;
    #1;
    check("zero_post_edge", RD1, 32'h0);
    sweep("zero_sweep");

    // Link write through the write-destination mux
    @(negedge CLK);
    WE = 1'b1; WA = wdst_mux(WDST_RA, 5'd3, 5'd4); WD = 32'h0000_0040;
    tick();
    @(negedge CLK);
    WE = 1'b0; RA2 = 5'd31;
    #1;
    check("link_rd2", RD2, 32'h0000_0040);

    // Read/write collision on $9
    @(negedge CLK);
    WE = 1'b1; WA = 5'd9; WD = 32'd5;
    tick();
    @(negedge CLK);
    WD = 32'd7; RA1 = 5'd9; RA2 = 5'd9;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("collide_pre_rd1", RD1, 32'd7);
    check("collide_pre_rd2", RD2, 32'd7);
`else
    check("collide_pre_rd1", RD1, 32'd5);
    check("collide_pre_rd2", RD2, 32'd5);
`endif
    tick();
    @(negedge CLK);
    WE = 1'b0;
    #1;
    check("collide_post_rd1", RD1, 32'd7);
    check("collide_post_rd2", RD2, 32'd7);

    // Reset pulse between edges wipes a live value immediately
    @(negedge CLK);
    WE = 1'b1; WA = 5'd10; WD = 32'hA5A5_A5A5;
    tick();
    @(negedge CLK);
    WE = 1'b0; RA1 = 5'd10; RA2 = 5'd29;
    #0.5;
    check("pre_rst_rd1", RD1, 32'hA5A5_A5A5);
    RST_N = 1'b0;
    model_reset();
    #1;
    check("midrst_rd1", RD1, 32'h0);
    check("midrst_rd2_sp", RD2, 32'h0000_3FFC);
    #2;
    RST_N = 1'b1;
    #0.5;
    check("postrst_rd1", RD1, 32'h0);
    tick();
    check("postrst_edge_rd1", RD1, 32'h0);
    sweep("postrst_sweep");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      WE    = 1'($urandom_range(0, 1));
      WA    = reg_addr_t'($urandom);
      WD    = $urandom;
      RA1   = reg_addr_t'($urandom);
      RA2   = ($urandom_range(0, 3) == 0) ? RA1 : reg_addr_t'($urandom);
      DBG_A = ($urandom_range(0, 3) == 0) ? WA : reg_addr_t'($urandom);
      #1;
      check("rnd_pre_rd1", RD1, exp_rd(RA1));
      check("rnd_pre_rd2", RD2, exp_rd(RA2));
      check("rnd_pre_dbg", DBG_D, exp_rd(DBG_A));
      tick();
      check("rnd_post_rd1", RD1, exp_rd(RA1));
      check("rnd_post_rd2", RD2, exp_rd(RA2));
      check("rnd_post_dbg", DBG_D, exp_rd(DBG_A));
    end

    @(negedge CLK);
    WE = 1'b0;
    sweep("final_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
